// File: rtl/coresub_sramwait_pkg.sv
// Shared types and widths for the SRAM wait-state sequencer.
package coresub_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } sramwait_st_e;

  localparam int WAITCYC_W = 2;
  localparam int ERRCNT_W  = 8;

endpackage

// File: rtl/coresub_sramwait_satcnt.sv
// Generic saturating up-counter with synchronous clear; clear+increment yields 1.
module coresub_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr && inc) begin
      cnt_d = W'(1);
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/coresub_sramwait.sv
// Wait-state sequencer between a bus request port and a single-port SRAM macro.
// Optional saturating error counter enabled by defining SRAMWAIT_ERRCNT_EN.
module coresub_sramwait
  import coresub_sram_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WAITCYC_W-1:0] waitcyc,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [AW-1:0]        req_addr,
  input  logic [DW-1:0]        req_wdata,
  input  logic [DW/8-1:0]      req_wmask,
  output logic                 rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic                 sram_ce,
  output logic                 sram_we,
  output logic [AW-1:0]        sram_addr,
  output logic [DW-1:0]        sram_wdata,
  output logic [DW/8-1:0]      sram_wmask,
  input  logic [DW-1:0]        sram_rdata,
  input  logic                 sram_err,
  input  logic                 errclr,
  output logic                 bankerr,
  output logic [ERRCNT_W-1:0]  errcnt
);

  localparam logic [WAITCYC_W-1:0] WC_ONE = 1;

  sramwait_st_e          state_q, state_d;
  logic [WAITCYC_W-1:0]  cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  ce_q, ce_d;
  logic                  we_q, we_d;
  logic                  write_q, write_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW/8-1:0]       wmask_q, wmask_d;
  logic                  bankerr_q, bankerr_d;
  logic                  accept;
  logic                  err_set;

  assign accept  = req_valid & ready_q;
  assign err_set = (state_q == RESP) & ~write_q & sram_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      IDLE: ;
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - WC_ONE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // ready_q is low in ACCESS, so an accept only ever lands in IDLE or RESP
    if (accept) begin
      state_d = ACCESS;
      cnt_d   = waitcyc;
      write_d = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      wmask_d = req_wmask;
    end
    ce_d      = (state_d == ACCESS);
    we_d      = ce_d & write_d;
    ready_d   = (state_d != ACCESS);
    bankerr_d = err_set | (bankerr_q & ~errclr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      bankerr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      ce_q      <= ce_d;
      we_q      <= we_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      bankerr_q <= bankerr_d;
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = (rsp_valid && !write_q) ? sram_rdata : '0;
  assign rsp_err    = rsp_valid & sram_err;
  assign sram_ce    = ce_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_wmask = wmask_q;
  assign bankerr    = bankerr_q;

`ifdef SRAMWAIT_ERRCNT_EN
  coresub_satcnt #(
    .W (ERRCNT_W)
  ) u_errcnt (
    .clk   (clk),
    .rst_n (resetn),
    .clr   (errclr),
    .inc   (err_set),
    .cnt   (errcnt)
  );
`else
  assign errcnt = '0;
`endif

endmodule

// File: tb/tb_coresub_sramwait.sv
// Self-checking bench for coresub_sramwait: cycle-window reference model plus directed scenarios.
module tb_coresub_sramwait;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [1:0]    waitcyc = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_wmask = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          sram_ce;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [3:0]    sram_wmask;
  logic [DW-1:0] sram_rdata = '0;
  logic          sram_err = 1'b0;
  logic          errclr = 1'b0;
  logic          bankerr;
  logic [7:0]    errcnt;

  always #5 clk = ~clk;

  coresub_sramwait #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .waitcyc    (waitcyc),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_wmask (sram_wmask),
    .sram_rdata (sram_rdata),
    .sram_err   (sram_err),
    .errclr     (errclr),
    .bankerr    (bankerr),
    .errcnt     (errcnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: an accept in cycle c owns CE for cycles c+1..c+1+wc and responds in c+2+wc.
  int            cyc = 0;
  int            ce_s = 1, ce_e = 0, rsp_c = -1;
  bit            m_up = 1'b0;
  bit            m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [3:0]    m_wmask = '0;
  bit            m_bankerr = 1'b0;
  int            m_errcnt = 0;
  bit            m_ready, m_rsp, m_set;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_up = 1'b0; ce_s = 1; ce_e = 0; rsp_c = -1;
      m_write = 1'b0; m_bankerr = 1'b0; m_errcnt = 0;
    end else begin
      m_ready = m_up && !(cyc >= ce_s && cyc <= ce_e);
      m_rsp   = (cyc == rsp_c);
      m_set   = m_rsp && !m_write && sram_err;
      if (m_set) m_bankerr = 1'b1;
      else if (errclr) m_bankerr = 1'b0;
`ifdef SRAMWAIT_ERRCNT_EN
      if (m_set) m_errcnt = errclr ? 1 : ((m_errcnt < 255) ? m_errcnt + 1 : 255);
      else if (errclr) m_errcnt = 0;
`endif
      if (req_valid && m_ready) begin
        m_write = req_write; m_addr = req_addr; m_wdata = req_wdata; m_wmask = req_wmask;
        ce_s  = cyc + 1;
        ce_e  = cyc + 1 + int'(waitcyc);
        rsp_c = cyc + 2 + int'(waitcyc);
      end
      m_up = 1'b1;
      cyc++;
    end
  end

  bit e_ce, e_rsp;
  always @(negedge clk) begin
    if (chk_en) begin
      e_ce  = (cyc >= ce_s && cyc <= ce_e);
      e_rsp = (cyc == rsp_c);
      chk("req_ready", 64'(req_ready), 64'(m_up && !e_ce));
      chk("sram_ce", 64'(sram_ce), 64'(e_ce));
      chk("sram_we", 64'(sram_we), 64'(e_ce && m_write));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      chk("rsp_rdata", 64'(rsp_rdata), (e_rsp && !m_write) ? 64'(sram_rdata) : 64'd0);
      chk("rsp_err", 64'(rsp_err), 64'(e_rsp && sram_err));
      chk("bankerr", 64'(bankerr), 64'(m_bankerr));
      chk("errcnt", 64'(errcnt), 64'(m_errcnt));
      if (e_ce) begin
        chk("sram_addr", 64'(sram_addr), 64'(m_addr));
        chk("sram_wdata", 64'(sram_wdata), 64'(m_wdata));
        chk("sram_wmask", 64'(sram_wmask), 64'(m_wmask));
      end
    end
  end

  // One access; afterwards observes 7 cycles and reports what the DUT did.
  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] m, input logic [1:0] wc, input logic [1:0] wc_after,
                       output int nce, output int nrsp, output int nbusy,
                       output logic [DW-1:0] rd, output logic [AW-1:0] ce_addr);
    bit got = 1'b0;
    waitcyc = wc; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    waitcyc = wc_after;
    nce = 0; nrsp = 0; nbusy = 0; rd = '0; ce_addr = '0;
    repeat (7) begin
      @(negedge clk);
      nce += int'(sram_ce);
      nbusy += int'(!req_ready);
      if (sram_ce) ce_addr = sram_addr;
      if (rsp_valid) begin nrsp++; rd = rsp_rdata; end
    end
  endtask

  int nce, nrsp, nbusy, nacc;
  logic [DW-1:0] rd;
  logic [AW-1:0] ca;

  initial begin
    #2 resetn = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", 64'(sram_ce), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1;

    // 1: waitcyc=0 read
    sram_rdata = 32'h1234_5678;
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 2'd0, 2'd0, nce, nrsp, nbusy, rd, ca);
    chk("t1_ce_cycles", 64'(nce), 64'd1);
    chk("t1_rsp_count", 64'(nrsp), 64'd1);
    chk("t1_rdata", 64'(rd), 64'h1234_5678);

    // 2: waitcyc=3 write
    issue(1'b1, 16'h0040, 32'hA5A5_5A5A, 4'hF, 2'd3, 2'd3, nce, nrsp, nbusy, rd, ca);
    chk("t2_ce_cycles", 64'(nce), 64'd4);
    chk("t2_busy_cycles", 64'(nbusy), 64'd4);
    chk("t2_rsp_count", 64'(nrsp), 64'd1);
    chk("t2_wr_rdata", 64'(rd), 64'd0);
    chk("t2_addr", 64'(ca), 64'h0040);

    // 3: waitcyc 1 -> 3 mid-access
    issue(1'b0, 16'h0100, 32'h0, 4'h0, 2'd1, 2'd3, nce, nrsp, nbusy, rd, ca);
    chk("t3_first_ce", 64'(nce), 64'd2);
    issue(1'b0, 16'h0101, 32'h0, 4'h0, 2'd3, 2'd3, nce, nrsp, nbusy, rd, ca);
    chk("t3_second_ce", 64'(nce), 64'd4);

    // 4: continuous requests, waitcyc=1
    waitcyc = 2'd1; req_write = 1'b0; req_addr = 16'h0200; req_valid = 1'b1;
    nacc = 0; nrsp = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      nacc += int'(req_valid && req_ready);
      nrsp += int'(rsp_valid);
      if (i == 29) req_valid = 1'b0;
    end
    chk("t4_accepts_30cyc", 64'(nacc), 64'd10);
    chk("t4_rsp_count", 64'(nrsp), 64'd10);
    repeat (4) @(posedge clk);
    #1;

    // 5: read error sets bankerr; clear colliding with set keeps it
    sram_err = 1'b1;
    issue(1'b0, 16'h0300, 32'h0, 4'h0, 2'd0, 2'd0, nce, nrsp, nbusy, rd, ca);
    chk("t5_bankerr_set", 64'(bankerr), 64'd1);
    waitcyc = 2'd0; req_write = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    errclr = 1'b1;
    @(posedge clk); #1;
    errclr = 1'b0;
    chk("t5_set_wins", 64'(bankerr), 64'd1);
    sram_err = 1'b0;
    errclr = 1'b1;
    @(posedge clk); #1;
    errclr = 1'b0;
    chk("t5_cleared", 64'(bankerr), 64'd0);
    sram_err = 1'b1;
    issue(1'b1, 16'h0301, 32'h1, 4'h1, 2'd0, 2'd0, nce, nrsp, nbusy, rd, ca);
    chk("t5_write_no_err", 64'(bankerr), 64'd0);
`ifdef SRAMWAIT_ERRCNT_EN
    for (int k = 0; k < 300; k++)
      issue(1'b0, 16'h0400, 32'h0, 4'h0, 2'd0, 2'd0, nce, nrsp, nbusy, rd, ca);
    chk("t5_errcnt_sat", 64'(errcnt), 64'd255);
`endif
    sram_err = 1'b0;

    // 6: reset during the second CE cycle, waitcyc=2
    waitcyc = 2'd2; req_write = 1'b0; req_addr = 16'h0500; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_ce_before_rst", 64'(sram_ce), 64'd1);
    resetn = 1'b0;
    #1;
    chk("t6_ce_dropped", 64'(sram_ce), 64'd0);
    chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    chk("t6_ready", 64'(req_ready), 64'd1);
    nrsp = 0;
    repeat (5) begin
      @(negedge clk);
      nrsp += int'(rsp_valid);
    end
    chk("t6_rsp_after", 64'(nrsp), 64'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
